// File: rtl/cpu_jogada_pkg.sv
// rtl/cpu_jogada_pkg.sv - cell encoding, FSM states and line table for the CPU move engine
package cpu_jogada_pkg;

  localparam logic [1:0] PLAYER = 2'd0;
  localparam logic [1:0] CPU    = 2'd1;
  localparam logic [1:0] VAZIO  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    GANHA,
    BLOQUEIA,
    ESCOLHE,
    PRONTO
  } estado_t;

  // Rows, columns, then the two diagonals.
  localparam logic [0:7][0:2][3:0] LINHAS = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Fallback preference: centre, corners, edges.
  localparam logic [0:8][3:0] PRIORIDADE = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  function automatic logic [1:0] celula(input logic [17:0] tab, input logic [3:0] idx);
    return tab[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/cpu_jogada_avalia_linha.sv
// rtl/cpu_jogada_avalia_linha.sv - detects two target cells plus one empty cell on a line
module avalia_linha
  import cpu_jogada_pkg::*;
(
  input  logic [1:0] cel0_i,
  input  logic [1:0] cel1_i,
  input  logic [1:0] cel2_i,
  input  logic [1:0] alvo_i,
  output logic       hit_o,
  output logic [1:0] offset_o
);

  logic [2:0] eh_alvo;
  logic [2:0] eh_vazio;

  assign eh_alvo  = {cel2_i == alvo_i, cel1_i == alvo_i, cel0_i == alvo_i};
  assign eh_vazio = {cel2_i == VAZIO,  cel1_i == VAZIO,  cel0_i == VAZIO};

  // The two sets are disjoint, so complementary masks mean exactly two targets and one empty.
  assign hit_o    = $onehot(eh_vazio) && (eh_alvo == ~eh_vazio);
  assign offset_o = eh_vazio[0] ? 2'd0 : (eh_vazio[1] ? 2'd1 : 2'd2);

endmodule

// File: rtl/cpu_jogada.sv
// rtl/cpu_jogada.sv - tic-tac-toe CPU move selector: win, block, then positional fallback
module cpu_jogada
  import cpu_jogada_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] tabuleiro,
  input  logic        pedido,
  input  logic        aceito,
  output logic        valido,
  output logic [3:0]  posicao,
  output logic [8:0]  posicao_oh,
  output logic        cheio,
  output logic        ocupado
);

  estado_t     estado_q, estado_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [17:0] tab_q, tab_d;
  logic [3:0]  pos_q, pos_d;
  logic [8:0]  oh_q, oh_d;
  logic        cheio_q, cheio_d;

  logic [0:2][3:0] linha_atual;
  logic [1:0]      alvo;
  logic            hit;
  logic [1:0]      offset;
  logic [3:0]      idx_vazio;
  logic            achou;
  logic [3:0]      escolha;

  assign linha_atual = LINHAS[cnt_q];
  assign alvo        = (estado_q == GANHA) ? CPU : PLAYER;

  avalia_linha u_avalia (
    .cel0_i   (celula(tab_q, linha_atual[0])),
    .cel1_i   (celula(tab_q, linha_atual[1])),
    .cel2_i   (celula(tab_q, linha_atual[2])),
    .alvo_i   (alvo),
    .hit_o    (hit),
    .offset_o (offset)
  );

  assign idx_vazio = (offset == 2'd0) ? linha_atual[0] :
                     (offset == 2'd1) ? linha_atual[1] : linha_atual[2];

  // Walk the preference list backwards so the highest-priority empty cell wins.
  always_comb begin
    achou   = 1'b0;
    escolha = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (celula(tab_q, PRIORIDADE[i]) == VAZIO) begin
        achou   = 1'b1;
        escolha = PRIORIDADE[i];
      end
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    tab_d    = tab_q;
    pos_d    = pos_q;
    oh_d     = oh_q;
    cheio_d  = cheio_q;
    case (estado_q)
      IDLE: begin
        if (pedido) begin
          tab_d    = tabuleiro;
          cnt_d    = 3'd0;
          estado_d = GANHA;
        end
      end
      GANHA, BLOQUEIA: begin
        if (hit) begin
          pos_d    = idx_vazio;
          oh_d     = 9'd1 << idx_vazio;
          cheio_d  = 1'b0;
          estado_d = PRONTO;
        end else if (cnt_q == 3'd7) begin
          cnt_d    = 3'd0;
          estado_d = (estado_q == GANHA) ? BLOQUEIA : ESCOLHE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ESCOLHE: begin
        pos_d    = achou ? escolha : 4'd0;
        oh_d     = achou ? (9'd1 << escolha) : 9'd0;
        cheio_d  = ~achou;
        estado_d = PRONTO;
      end
      PRONTO: begin
        if (aceito) estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= IDLE;
      cnt_q    <= 3'd0;
      tab_q    <= {9{VAZIO}};
      pos_q    <= 4'd0;
      oh_q     <= 9'd0;
      cheio_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      tab_q    <= tab_d;
      pos_q    <= pos_d;
      oh_q     <= oh_d;
      cheio_q  <= cheio_d;
    end
  end

  assign valido     = (estado_q == PRONTO);
  assign ocupado    = (estado_q != IDLE);
  assign posicao    = pos_q;
  assign posicao_oh = oh_q;
  assign cheio      = cheio_q;

endmodule

// File: tb/tb_cpu_jogada.sv
// tb/tb_cpu_jogada.sv - randomized self-checking bench for cpu_jogada against a rule-level model
module tb_cpu_jogada;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [17:0] tabuleiro = '0;
  logic        pedido = 1'b0;
  logic        aceito = 1'b0;
  logic        valido;
  logic [3:0]  posicao;
  logic [8:0]  posicao_oh;
  logic        cheio;
  logic        ocupado;

  int n_checks = 0;
  int n_errors = 0;

  int linhas[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int ordem[9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

  cpu_jogada dut (
    .clock      (clock),
    .reset      (reset),
    .tabuleiro  (tabuleiro),
    .pedido     (pedido),
    .aceito     (aceito),
    .valido     (valido),
    .posicao    (posicao),
    .posicao_oh (posicao_oh),
    .cheio      (cheio),
    .ocupado    (ocupado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Latency counts rising edges from the request edge (inclusive) to the edge that raises valido.
  function automatic void modelo(input logic [17:0] b, output int pos, output bit full, output int lat);
    int c[9];
    int alvo, na, nv, ev;
    for (int i = 0; i < 9; i++) c[i] = int'(b[2*i +: 2]);
    pos  = -1;
    full = 0;
    lat  = 18;
    for (int pass = 0; pass < 2; pass++) begin
      alvo = (pass == 0) ? 1 : 0;
      for (int k = 0; k < 8; k++) begin
        na = 0; nv = 0; ev = -1;
        for (int j = 0; j < 3; j++) begin
          if (c[linhas[k][j]] == alvo) na++;
          if (c[linhas[k][j]] == 2) begin nv++; ev = linhas[k][j]; end
        end
        if (pos < 0 && na == 2 && nv == 1) begin
          pos = ev;
          lat = pass * 8 + k + 2;
        end
      end
    end
    if (pos < 0) begin
      for (int i = 8; i >= 0; i--)
        if (c[ordem[i]] == 2) pos = ordem[i];
      if (pos < 0) begin
        full = 1;
        pos  = 0;
      end
    end
  endfunction

  function automatic logic [17:0] monta(input int c[9]);
    logic [17:0] b;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(c[i]);
    return b;
  endfunction

  task automatic run_move(input logic [17:0] b, input int hold, input bit ruido);
    int pos, lat, n;
    bit full;
    logic [8:0] oh_exp;
    modelo(b, pos, full, lat);
    oh_exp = full ? 9'd0 : (9'd1 << pos);
    @(negedge clock);
    tabuleiro = b;
    pedido    = 1'b1;
    n = 0;
    while (n < 40 && valido !== 1'b1) begin
      @(posedge clock);
      #1;
      n++;
      pedido = ruido ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ruido) tabuleiro = 18'($urandom);
      if (n == 1 && lat > 2) check("ocupado_scan", ocupado, 1);
    end
    check("latencia", n, lat);
    if (!full) check("posicao", posicao, pos);
    check("posicao_oh", posicao_oh, oh_exp);
    check("cheio", cheio, full);
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      #1;
      check("hold_valido", valido, 1);
      check("hold_oh", posicao_oh, oh_exp);
    end
    aceito = 1'b1;
    @(posedge clock);
    #1;
    aceito = 1'b0;
    pedido = 1'b0;
    check("ack_valido", valido, 0);
    check("ack_ocupado", ocupado, 0);
  endtask

  initial begin
    int c[9];
    int seen;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valido", valido, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_posicao", posicao, 0);
    check("rst_oh", posicao_oh, 0);
    check("rst_cheio", cheio, 0);
    reset = 1'b1;

    c = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    run_move(monta(c), 0, 0);
    c = '{1, 1, 2, 0, 0, 2, 2, 2, 2};
    run_move(monta(c), 0, 0);
    c = '{2, 2, 0, 2, 1, 2, 0, 2, 2};
    run_move(monta(c), 0, 0);
    c = '{0, 1, 0, 0, 1, 1, 1, 0, 0};
    run_move(monta(c), 0, 0);
    c = '{3, 3, 3, 3, 3, 3, 3, 3, 2};
    run_move(monta(c), 0, 0);
    c = '{1, 2, 2, 0, 2, 2, 1, 2, 2};
    run_move(monta(c), 5, 1);

    // Abort a scan in its fifth cycle; no result may surface afterwards.
    c = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    @(negedge clock);
    tabuleiro = monta(c);
    pedido = 1'b1;
    @(posedge clock);
    #1;
    pedido = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_valido", valido, 0);
    check("midrst_ocupado", ocupado, 0);
    check("midrst_oh", posicao_oh, 0);
    reset = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clock);
      #1;
      if (valido === 1'b1) seen++;
    end
    check("midrst_no_result", seen, 0);
    run_move(monta(c), 0, 0);

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 9; i++) begin
        int r;
        r = $urandom_range(0, 9);
        c[i] = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      end
      run_move(monta(c), (t % 10 == 0) ? 3 : 0, t[0]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
